// File: rtl/cache_nwsa_wb.sv
// N-way set-associative write-back cache: byte-wide CPU port, byte-serial memory port.
// Invalid ways are filled first; otherwise each set replaces round-robin.

module cache_nwsa_wb_way #(
  parameter int TAGW = 4
) (
  input  logic            valid,
  input  logic [TAGW-1:0] tag,
  input  logic [TAGW-1:0] req_tag,
  output logic            hit
);
  assign hit = valid && (tag == req_tag);
endmodule

module cache_nwsa_wb #(
  parameter int AWIDTH    = 9,
  parameter int DWIDTH    = 8,
  parameter int WAYS      = 2,
  parameter int SETS      = 8,
  parameter int BLOCKSIZE = 4,
  parameter int CNTWIDTH  = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [AWIDTH-1:0]   cpu_addr,
  input  logic [DWIDTH-1:0]   cpu_wdata,
  output logic [DWIDTH-1:0]   cpu_rdata,
  output logic                cpu_ack,
  output logic                cpu_busy,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [DWIDTH-1:0]   mem_wdata,
  input  logic [DWIDTH-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic [CNTWIDTH-1:0] miss_cnt
);
  localparam int OFFW = $clog2(BLOCKSIZE);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = AWIDTH - IDXW - OFFW;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_e;
  typedef struct packed {
    logic              we;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
  } req_t;
  typedef logic [BLOCKSIZE-1:0][DWIDTH-1:0] line_t;

  state_e                     state_q, state_d;
  req_t                       req_q, req_d;
  logic [SETS-1:0][WAYS-1:0]  valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0]  dirty_q, dirty_d;
  logic [SETS-1:0][WW-1:0]    rr_q, rr_d;
  logic [OFFW-1:0]            beat_q, beat_d;
  logic [WW-1:0]              vic_q, vic_d;
  logic [CNTWIDTH-1:0]        miss_q, miss_d;
  line_t                      buf_q, buf_d;
  logic                       ack_q, ack_d;
  logic [DWIDTH-1:0]          rdata_q, rdata_d;

  logic [TAGW-1:0] tag_mem  [SETS][WAYS];
  line_t           data_mem [SETS][WAYS];

  logic            arr_we;
  logic [WW-1:0]   arr_way;
  line_t           arr_line;

  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] req_idx;
  logic [OFFW-1:0] req_off;
  assign {req_tag, req_idx, req_off} = req_q.addr;

  logic [WAYS-1:0] way_hit;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_nwsa_wb_way #(.TAGW(TAGW)) u_way (
      .valid   (valid_q[req_idx][w]),
      .tag     (tag_mem[req_idx][w]),
      .req_tag (req_tag),
      .hit     (way_hit[w])
    );
  end

  logic [WW-1:0] hit_way, inv_way, vic_sel;
  logic          any_inv;
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    // Descending scan so the lowest-index match wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) hit_way = WW'(w);
      if (!valid_q[req_idx][w]) begin
        inv_way = WW'(w);
        any_inv = 1'b1;
      end
    end
    vic_sel = any_inv ? inv_way : rr_q[req_idx];
  end

  line_t           hit_line, vic_line;
  logic [TAGW-1:0] vic_tag;
  assign hit_line = data_mem[req_idx][hit_way];
  assign vic_line = data_mem[req_idx][vic_q];
  assign vic_tag  = tag_mem[req_idx][vic_q];

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    vic_d     = vic_q;
    miss_d    = miss_q;
    buf_d     = buf_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    arr_we    = 1'b0;
    arr_way   = hit_way;
    arr_line  = hit_line;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: if (cpu_req) begin
        req_d   = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        state_d = LOOKUP;
      end
      LOOKUP: if (|way_hit) begin
        ack_d   = 1'b1;
        state_d = IDLE;
        if (req_q.we) begin
          arr_we                     = 1'b1;
          arr_line[req_off]          = req_q.wdata;
          dirty_d[req_idx][hit_way]  = 1'b1;
          rdata_d                    = req_q.wdata;
        end else begin
          rdata_d = hit_line[req_off];
        end
      end else begin
        vic_d  = vic_sel;
        beat_d = '0;
        if (miss_q != {CNTWIDTH{1'b1}}) miss_d = miss_q + CNTWIDTH'(1);
        state_d = (valid_q[req_idx][vic_sel] && dirty_q[req_idx][vic_sel]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_wr    = 1'b1;
        mem_addr  = {vic_tag, req_idx, beat_q};
        mem_wdata = vic_line[beat_q];
        if (mem_ack) begin
          beat_d = beat_q + OFFW'(1);
          if (beat_q == OFFW'(BLOCKSIZE - 1)) begin
            beat_d  = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        mem_rd   = 1'b1;
        mem_addr = {req_tag, req_idx, beat_q};
        if (mem_ack) begin
          buf_d[beat_q] = mem_rdata;
          beat_d        = beat_q + OFFW'(1);
          if (beat_q == OFFW'(BLOCKSIZE - 1)) begin
            beat_d  = '0;
            state_d = RESPOND;
          end
        end
      end
      RESPOND: begin
        arr_we   = 1'b1;
        arr_way  = vic_q;
        arr_line = buf_q;
        if (req_q.we) arr_line[req_off] = req_q.wdata;
        rdata_d  = req_q.we ? req_q.wdata : buf_q[req_off];
        valid_d[req_idx][vic_q] = 1'b1;
        dirty_d[req_idx][vic_q] = req_q.we;
        if (WAYS > 1) rr_d[req_idx] = rr_q[req_idx] + WW'(1);
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      vic_q   <= '0;
      miss_q  <= '0;
      buf_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      vic_q   <= vic_d;
      miss_q  <= miss_d;
      buf_q   <= buf_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Tag/data storage carries no reset; valid bits gate every use of it.
  always_ff @(posedge clock) begin
    if (arr_we) begin
      tag_mem[req_idx][arr_way]  <= req_tag;
      data_mem[req_idx][arr_way] <= arr_line;
    end
  end

  assign cpu_ack   = ack_q;
  assign cpu_rdata = rdata_q;
  assign cpu_busy  = (state_q != IDLE);
  assign miss_cnt  = miss_q;
endmodule

// File: tb/tb_cache_nwsa_wb.sv
// Directed bench for cache_nwsa_wb: table of sequential accesses plus hand-written
// stall, busy, idle-ack and mid-writeback reset sequences against a byte memory model.
module tb_cache_nwsa_wb;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_busy;
  logic [8:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic [15:0] miss_cnt;

  cache_nwsa_wb dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int ack_count = 0;

  logic [7:0] mem [512];
  logic [8:0] rd_log[$];
  logic [8:0] wr_log[$];
  logic [7:0] wd_log[$];
  bit         ack_force = 1'b0;
  bit         stall_arm = 1'b0;
  int         stall_left = 0;
  logic [8:0] stall_addr = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: decides ack at the falling edge, DUT samples at the rising edge.
  always @(negedge clock) begin
    mem_ack = 1'b0;
    if (cpu_ack) ack_count++;
    if (reset_n) begin
      total++;
      if (mem_rd && mem_wr) begin
        bad++;
        $display("FAIL rd_wr_both: got rd=%0b wr=%0b expected not both", mem_rd, mem_wr);
      end
      if (ack_force) mem_ack = 1'b1;
      else if (mem_rd || mem_wr) begin
        if (stall_arm && mem_rd && mem_addr[1:0] == 2'd2) begin
          stall_arm  = 1'b0;
          stall_left = 5;
          stall_addr = mem_addr;
        end
        if (stall_left > 0) begin
          stall_left--;
          total++;
          if (!(mem_rd && mem_addr == stall_addr)) begin
            bad++;
            $display("FAIL stall_hold: got rd=%0b addr=%0h expected rd=1 addr=%0h",
                     mem_rd, mem_addr, stall_addr);
          end
        end else begin
          mem_ack = 1'b1;
          if (mem_rd) begin
            rd_log.push_back(mem_addr);
            mem_rdata = mem[mem_addr];
          end else begin
            wr_log.push_back(mem_addr);
            wd_log.push_back(mem_wdata);
            mem[mem_addr] = mem_wdata;
          end
        end
      end
    end
  end

  task automatic access(input logic we, input logic [8:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output int lat, output bit ok);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    rd_log.delete(); wr_log.delete(); wd_log.delete();
    ok = 1'b0; lat = 0; rd = '0;
    @(negedge clock);
    cpu_req = 1'b0;
    for (int i = 1; i < 200; i++) begin
      lat = i;
      if (cpu_ack) begin
        ok = 1'b1;
        rd = cpu_rdata;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_ack"},   cpu_ack,   0);
    chk({tag, "_busy"},  cpu_busy,  0);
    chk({tag, "_maddr"}, mem_addr,  0);
    chk({tag, "_mrd"},   mem_rd,    0);
    chk({tag, "_mwr"},   mem_wr,    0);
    chk({tag, "_mwd"},   mem_wdata, 0);
    chk({tag, "_miss"},  miss_cnt,  0);
  endtask

  typedef struct {
    logic       we;
    logic [8:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    int         exp_miss;
    int         exp_rds;
    logic [8:0] rd0;
    int         exp_wrs;
    logic [8:0] wr0;
    logic [7:0] wd0;
    bit         hit;
  } vec_t;

  vec_t       vt[13];
  logic [7:0] rd;
  int         lat, n, a0;
  bit         ok;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 8'(a) ^ 8'h3C;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;

    //          we  addr    wd     rdata  miss rds rd0     wrs wr0     wd0    hit
    vt[0]  = '{1'b0, 9'h004, 8'h00, 8'h11, 1, 4, 9'h004, 0, 9'h000, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 9'h006, 8'h00, 8'h33, 1, 0, 9'h000, 0, 9'h000, 8'h00, 1'b1};
    vt[2]  = '{1'b1, 9'h005, 8'hAA, 8'hAA, 1, 0, 9'h000, 0, 9'h000, 8'h00, 1'b1};
    vt[3]  = '{1'b0, 9'h005, 8'h00, 8'hAA, 1, 0, 9'h000, 0, 9'h000, 8'h00, 1'b1};
    vt[4]  = '{1'b1, 9'h004, 8'h5A, 8'h5A, 1, 0, 9'h000, 0, 9'h000, 8'h00, 1'b1};
    vt[5]  = '{1'b0, 9'h024, 8'h00, 8'h18, 2, 4, 9'h024, 0, 9'h000, 8'h00, 1'b0};
    vt[6]  = '{1'b0, 9'h044, 8'h00, 8'h78, 3, 4, 9'h044, 4, 9'h004, 8'h5A, 1'b0};
    vt[7]  = '{1'b0, 9'h025, 8'h00, 8'h19, 3, 0, 9'h000, 0, 9'h000, 8'h00, 1'b1};
    vt[8]  = '{1'b0, 9'h004, 8'h00, 8'h5A, 4, 4, 9'h004, 0, 9'h000, 8'h00, 1'b0};
    vt[9]  = '{1'b1, 9'h0E3, 8'h77, 8'h77, 5, 4, 9'h0E0, 0, 9'h000, 8'h00, 1'b0};
    vt[10] = '{1'b0, 9'h0E3, 8'h00, 8'h77, 5, 0, 9'h000, 0, 9'h000, 8'h00, 1'b1};
    vt[11] = '{1'b0, 9'h0E0, 8'h00, 8'hDC, 5, 0, 9'h000, 0, 9'h000, 8'h00, 1'b1};
    vt[12] = '{1'b0, 9'h044, 8'h00, 8'h78, 5, 0, 9'h000, 0, 9'h000, 8'h00, 1'b1};

    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #1;
    chk_zero_outs("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      access(vt[i].we, vt[i].addr, vt[i].wd, rd, lat, ok);
      chk($sformatf("v%0d_ack", i),   ok, 1);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_miss", i),  miss_cnt, vt[i].exp_miss);
      chk($sformatf("v%0d_nrd", i),   rd_log.size(), vt[i].exp_rds);
      chk($sformatf("v%0d_nwr", i),   wr_log.size(), vt[i].exp_wrs);
      if (vt[i].exp_rds > 0 && rd_log.size() > 0) chk($sformatf("v%0d_rd0", i), rd_log[0], vt[i].rd0);
      if (vt[i].exp_wrs > 0 && wr_log.size() > 0) begin
        chk($sformatf("v%0d_wr0", i), wr_log[0], vt[i].wr0);
        chk($sformatf("v%0d_wd0", i), wd_log[0], vt[i].wd0);
      end
      if (vt[i].hit) chk($sformatf("v%0d_hitlat", i), lat, 2);
    end
    chk("wb_mem5", mem[5], 8'hAA);
    chk("wb_mem6", mem[6], 8'h33);

    // mem_ack with no transfer in flight must be ignored.
    @(negedge clock); ack_force = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("idle_ack_busy", cpu_busy, 0);
    chk("idle_ack_miss", miss_cnt, 5);
    ack_force = 1'b0;

    // Five-cycle stall on refill beat 2.
    stall_arm = 1'b1;
    access(1'b0, 9'h105, 8'h00, rd, lat, ok);
    chk("stall_ack", ok, 1);
    chk("stall_rdata", rd, 8'h39);
    chk("stall_seen", stall_arm, 0);
    chk("stall_nrd", rd_log.size(), 4);
    access(1'b0, 9'h106, 8'h00, rd, lat, ok);
    chk("stall_byte2", rd, 8'h3A);
    chk("stall_byte2_nrd", rd_log.size(), 0);
    chk("stall_byte2_lat", lat, 2);

    // cpu_req pulse during refill is ignored; exactly one ack.
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h184; cpu_wdata = 8'h00;
    #1 a0 = ack_count;
    @(negedge clock); cpu_req = 1'b0;
    n = 0;
    while (!mem_rd && n < 50) begin @(negedge clock); n++; end
    chk("busy_refill_seen", mem_rd, 1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h0E3; cpu_wdata = 8'h00;
    @(negedge clock); cpu_req = 1'b0;
    n = 0;
    while (!cpu_ack && n < 50) begin @(negedge clock); n++; end
    chk("busy_ack", cpu_ack, 1);
    chk("busy_rdata", cpu_rdata, 8'hB8);
    chk("busy_miss", miss_cnt, 7);
    repeat (4) @(negedge clock);
    #1 chk("busy_one_ack", ack_count - a0, 1);
    access(1'b0, 9'h0E3, 8'h00, rd, lat, ok);
    chk("busy_ignored_wr", rd, 8'h77);

    // Reset in the middle of a writeback.
    access(1'b1, 9'h104, 8'h99, rd, lat, ok);
    chk("dirty_hit_lat", lat, 2);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h1C4;
    @(negedge clock); cpu_req = 1'b0;
    n = 0;
    while (!mem_wr && n < 50) begin @(negedge clock); n++; end
    chk("rst_wb_seen", mem_wr, 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk_zero_outs("rst_mid");
    a0 = ack_count;
    repeat (3) @(negedge clock);
    #1;
    chk_zero_outs("rst_hold");
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    #1 chk("rst_no_ack", ack_count - a0, 0);
    access(1'b0, 9'h0E3, 8'h00, rd, lat, ok);
    chk("rst_after_ack", ok, 1);
    chk("rst_after_rdata", rd, 8'hDF);
    chk("rst_after_miss", miss_cnt, 1);
    chk("rst_after_nrd", rd_log.size(), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
